bau_seq: RTL and testbench

- Sequential, parametrised successor to the BIP add/sub arithmetic unit.
- Registered two's-complement ALU: single-cycle ADD/SUB/AND/OR/XOR/SLL/SRA, plus an iterative shift-add signed multiply.
- Adds a start/busy/done handshake and registered status flags (zero, negative, overflow).
- Sits between the BIP datapath operand registers and the accumulator write-back; the control unit issues `start` and stalls on `busy`.

---
 rtl/bau_seq.sv | 174 +++++++++++++++++
 tb/tb_bau_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bau_seq.sv
// rtl/bau_seq.sv - registered two's-complement ALU with iterative signed multiply
//
// Purpose: single-cycle ADD/SUB/AND/OR/XOR/SLL/SRA and a WIDTH-cycle shift-add
// signed MUL behind a start/busy/done handshake, with registered zero/neg/ovf.
// Optional feature macro: BAU_SAT_EN (ADD/SUB/MUL saturate on signed overflow).
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high reset
//   start  - operation request, sampled only while idle
//   op     - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRA, 111 MUL
//   a, b   - signed operands; shift amount is b[SHW:0] (unsigned)
//   result - registered result, held until the next completion
//   zero   - result == 0
//   neg    - result sign bit
//   ovf    - signed overflow of the last operation
//   busy   - high while a multiply is iterating
//   done   - one-cycle pulse after result/flags are written
module bau_seq #(
    parameter int WIDTH = 11,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [SHW:0] SH_LIM = (SHW + 1)'(WIDTH);

`ifdef BAU_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic               msign;

    // single-cycle ALU path
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic [SHW:0]            shamt;
    logic signed [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ovf;

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        shamt   = b[SHW:0];
        sra_v   = $signed(a) >>> shamt;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLL: alu_res = (shamt >= SH_LIM) ? '0 : (a << shamt);
            OP_SRA: alu_res = (shamt >= SH_LIM) ? {WIDTH{a[MSB]}} : sra_v;
            default: ;
        endcase
`ifdef BAU_SAT_EN
        // an overflowing ADD/SUB always overflows toward the sign of a
        if (alu_ovf)
            alu_res = a[MSB] ? SMIN : SMAX;
`endif
    end

    // one shift-add multiply step; magnitudes are unsigned so |-2^(WIDTH-1)|
    // still fits in WIDTH bits, and the extra sum bit carries into the shift
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH:0]   prod_s;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_ovf;

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_nx  = {mul_sum, acc[WIDTH-1:1]};
        prod_s  = msign ? -{1'b0, acc_nx} : {1'b0, acc_nx};
        // fits in WIDTH signed bits only if all bits from MSB upward agree
        mul_ovf = (prod_s[2*WIDTH:MSB] != '0) && (prod_s[2*WIDTH:MSB] != '1);
        mul_res = prod_s[WIDTH-1:0];
`ifdef BAU_SAT_EN
        if (mul_ovf)
            mul_res = msign ? SMIN : SMAX;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            msign  <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand <= a[MSB] ? -a : a;
                            acc   <= {{WIDTH{1'b0}}, (b[MSB] ? -b : b)};
                            msign <= a[MSB] ^ b[MSB];
                            cnt   <= CW'(WIDTH);
                            busy  <= 1'b1;
                            state <= S_MUL;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                            neg    <= alu_res[MSB];
                            ovf    <= alu_ovf;
                            done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= acc_nx;
                    cnt <= cnt - CW'(1);
                    // the last step and the write-back share this edge
                    if (cnt == CW'(1)) begin
                        result <= mul_res;
                        zero   <= (mul_res == '0);
                        neg    <= mul_res[MSB];
                        ovf    <= mul_ovf;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bau_seq.sv
// tb/tb_bau_seq.sv - scoreboard bench for bau_seq with integer reference model
module tb_bau_seq;
    localparam int W   = 11;
    localparam int SHW = $clog2(W);
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));
`ifdef BAU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         busy;
    logic         done;

    bau_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .zero(zero), .neg(neg), .ovf(ovf), .busy(busy), .done(done)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         ov;
        int           due;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   nchk  = 0;
    int   nfail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        nchk++;
        if (act != expv) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // reference: exact integer arithmetic, then range check and wrap/saturate
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint xi = longint'($signed(x));
        longint yi = longint'($signed(y));
        longint full;
        int     sh = int'(y[SHW:0]);
        bit     arith = 1'b0;
        case (o)
            3'd0: begin full = xi + yi; arith = 1'b1; end
            3'd1: begin full = xi - yi; arith = 1'b1; end
            3'd2: full = xi & yi;
            3'd3: full = xi | yi;
            3'd4: full = xi ^ yi;
            3'd5: full = (sh >= W) ? 0 : xi * (64'sd1 <<< sh);
            3'd6: full = (sh >= W) ? ((xi < 0) ? -1 : 0) : (xi >>> sh);
            default: begin full = xi * yi; arith = 1'b1; end
        endcase
        e.ov  = arith && (full > MAXV || full < MINV);
        e.res = full[W-1:0];
        if (SAT && e.ov)
            e.res = (full > 0) ? MAXV[W-1:0] : MINV[W-1:0];
        e.due = 0;
        return e;
    endfunction

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic eo, input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) begin
            e.res = er;
            e.ov  = eo;
            e.due = cyc + 1 + ((o == 3'b111) ? W : 0);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_m(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t m;
        m = model(o, x, y);
        send(o, x, y, m.res, m.ov, 1'b1);
    endtask

    // cycles while a multiply iterates, with ignored start pulses as noise
    task automatic mul_gap();
        for (int j = 0; j < W; j++) begin
            start = 1'($urandom_range(1, 0));
            op    = 3'($urandom_range(7, 0));
            a     = W'($urandom);
            b     = W'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] v;
        case ($urandom_range(7, 0))
            0: v = MINV[W-1:0];
            1: v = MAXV[W-1:0];
            2: v = '0;
            3: v = '1;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // monitor: every done pulse must match the oldest outstanding expectation
    exp_t me;
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                me = q.pop_front();
                chk("result", result, me.res);
                chk("ovf", ovf, me.ov);
                chk("zero", zero, (me.res == '0));
                chk("neg", neg, me.res[W-1]);
                chk("done_cycle", cyc, me.due);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ro;
        int         k;
        reset = 1'b1;
        start = 1'b1;
        op    = 3'b000;
        a     = W'(1);
        b     = W'(1);
        idle(3);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_neg", neg, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        start = 1'b0;
        idle(1);
        chk("post_rst_done", done, 0);

        send(3'b000, W'(1000), W'(100), SAT ? W'(1023) : W'(-948), 1'b1, 1'b1);
        idle(1);
        send(3'b001, W'(5), W'(5), W'(0), 1'b0, 1'b1);
        send(3'b100, W'(12'h0F0), W'(12'h00F), W'(12'h0FF), 1'b0, 1'b1);
        idle(1);
        send(3'b101, W'(1), W'(12), W'(0), 1'b0, 1'b1);
        send(3'b110, W'(-512), W'(3), W'(-64), 1'b0, 1'b1);
        send(3'b110, W'(-512), W'(15), W'(-1), 1'b0, 1'b1);
        idle(1);

        send(3'b111, W'(-12), W'(34), W'(-408), 1'b0, 1'b1);
        for (int j = 0; j < W; j++) begin
            chk("mul_busy_high", busy, 1);
            start = (j % 2 == 0);
            op    = 3'b000;
            a     = W'(7);
            b     = W'(7);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("mul_busy_low", busy, 0);
        idle(1);

        send(3'b111, W'(100), W'(100), SAT ? W'(1023) : W'(-240), 1'b1, 1'b1);
        mul_gap();
        send(3'b111, W'(-1024), W'(-1), SAT ? W'(1023) : W'(-1024), 1'b1, 1'b1);
        mul_gap();
        // repeat of 100*100, aborted by reset partway through
        send(3'b111, W'(100), W'(100), W'(0), 1'b0, 1'b0);
        idle(4);
        reset = 1'b1;
        idle(1);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_zero", zero, 1);
        chk("abort_done", done, 0);
        reset = 1'b0;
        idle(W + 3);

        for (int i = 0; i < 300; i++) begin
            ro = 3'($urandom_range(7, 0));
            send_m(ro, rand_opnd(), rand_opnd());
            if (ro == 3'b111)
                mul_gap();
            else if ($urandom_range(3, 0) == 0)
                idle(1);
        end

        k = 0;
        while (q.size() != 0 && k < 4 * W) begin
            idle(1);
            k++;
        end
        idle(2);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
